// File: rtl/sync_debounce_bank_pkg.sv
// Shared constants for the calculator input conditioners: board clock,
// debounce window and the constant clog2 used to size the debounce counters.
package sync_debounce_bank_pkg;

   localparam int CLK_HZ      = 32'sd100000000;
   localparam int DEBOUNCE_MS = 32'sd10;

   // Default debounce window: DEBOUNCE_MS worth of clock cycles (10 ms at 100 MHz).
   localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 32'sd1000) * DEBOUNCE_MS;

   // Ceiling log2 usable in constant expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 32'sd0;
      v      = value - 32'sd1;
      while (v > 32'sd0) begin
         result = result + 32'sd1;
         v      = v >>> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_debounce_bank_channel.sv
// One input conditioner: SYNC_STAGES-deep synchroniser, saturating debounce
// counter, registered level and one-cycle rise/fall strobes.
module debounce_channel
   import sync_debounce_bank_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam int               CNT_W   = clog2(DEBOUNCE_CYCLES) + 32'sd1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'sd1);

   // Power-up values match the post-reset state.
   logic [SYNC_STAGES-1:0] r_sync = '0;
   logic [CNT_W-1:0]       r_cnt  = '0;
   logic                   r_dout = 1'b0;
   logic                   r_rise = 1'b0;
   logic                   r_fall = 1'b0;

   logic                   w_sy;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic                   w_dout_nxt;
   logic                   w_rise_nxt;
   logic                   w_fall_nxt;

   assign w_sy = r_sync[SYNC_STAGES-1];

   if (SYNC_STAGES == 1) begin : g_sync_single
      // Single-flop synchroniser.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_sync <= 1'b0;
         end else begin
            r_sync <= din;
         end
      end
   end else begin : g_sync_chain
      // Shift chain: stage 0 samples the raw input, the last stage is the synchronised value.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_sync <= '0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
         end
      end
   end

   // Debounce decision: count while sy disagrees with dout, commit on the last count.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_dout_nxt = r_dout;
      w_rise_nxt = 1'b0;
      w_fall_nxt = 1'b0;
      if (w_sy == r_dout) begin
         w_cnt_nxt = '0;
      end else if (r_cnt >= CNT_MAX) begin
         // Window complete: adopt sy and fire exactly one strobe.
         w_cnt_nxt  = '0;
         w_dout_nxt = w_sy;
         w_rise_nxt = w_sy;
         w_fall_nxt = ~w_sy;
      end else begin
         w_cnt_nxt = r_cnt + CNT_ONE;
      end
   end

   // Counter, level and strobe registers; reset discards any count in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_dout <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_dout <= w_dout_nxt;
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
      end
   end

   assign dout = r_dout;
   assign rise = r_rise;
   assign fall = r_fall;

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of CHANNELS independent synchronise-and-debounce conditioners for the
// calculator's push-buttons and switches.
module sync_debounce_bank
   import sync_debounce_bank_pkg::*;
#(
   parameter int CHANNELS        = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   if (SYNC_STAGES < 1) begin : g_bad_sync_stages
      $error("sync_debounce_bank: SYNC_STAGES must be >= 1");
   end

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
      $error("sync_debounce_bank: DEBOUNCE_CYCLES must be >= 1");
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_channel (
         .clk (clk),
         .rst (rst),
         .din (din[g]),
         .dout(dout[g]),
         .rise(rise[g]),
         .fall(fall[g])
      );
   end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Scoreboard bench for sync_debounce_bank with CHANNELS=5, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Each stimulus cycle pushes the hand-computed outputs
// expected after that clock edge; a monitor pops and compares at the
// following falling edge.
module tb_sync_debounce_bank;

   bit         clk;
   logic       rst;
   logic [4:0] din;
   logic [4:0] dout;
   logic [4:0] rise;
   logic [4:0] fall;

   typedef struct {
      int         tag;
      int         edge_n;
      logic [4:0] d;
      logic [4:0] r;
      logic [4:0] f;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;

   sync_debounce_bank #(
      .CHANNELS       (5),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .din (din),
      .dout(dout),
      .rise(rise),
      .fall(fall)
   );

   // 10-unit clock, first rising edge at t=5.
   initial begin
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic cyc(input int tag, input int edge_n, input logic [4:0] d_in, input logic r_in,
                      input logic [4:0] ed, input logic [4:0] er, input logic [4:0] ef);
      exp_t e;
      din = d_in;
      rst = r_in;
      e.tag    = tag;
      e.edge_n = edge_n;
      e.d      = ed;
      e.r      = er;
      e.f      = ef;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int tag);
      cyc(tag, 0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000);
   endtask

   // Compare DUT outputs against the scoreboard on every falling edge.
   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dout !== e.d || rise !== e.r || fall !== e.f) begin
               errors++;
               $display("FAIL scen%0d edge%0d dout/rise/fall got %b/%b/%b expected %b/%b/%b",
                        e.tag, e.edge_n, dout, rise, fall, e.d, e.r, e.f);
            end
            checks++;
            if ((rise & fall) !== 5'b00000) begin
               errors++;
               $display("FAIL excl scen%0d edge%0d rise %b fall %b expected no common bit",
                        e.tag, e.edge_n, rise, fall);
            end
         end
      end
   endtask

   initial begin
      din    = 5'b00000;
      rst    = 1'b0;
      checks = 0;
      errors = 0;
      fork
         monitor_loop();
      join_none

      // Scenario 0: power-up state with no reset, then a reset edge.
      cyc(0, 0, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000);
      do_reset(0);

      // Scenario 1: clean step on ch0, dout/rise at edge 6 only.
      for (int e = 1; e <= 8; e++) begin
         cyc(1, e, 5'b00001, 1'b0,
             (e >= 6) ? 5'b00001 : 5'b00000,
             (e == 6) ? 5'b00001 : 5'b00000,
             5'b00000);
      end
      do_reset(1);

      // Scenario 2: ch1 pulse of 3 cycles (sy high 3 cycles) is rejected.
      for (int e = 1; e <= 10; e++) begin
         cyc(2, e, (e <= 3) ? 5'b00010 : 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000);
      end
      do_reset(2);

      // Scenario 3: ch1 pulse of 4 cycles is accepted, then released after another window.
      for (int e = 1; e <= 12; e++) begin
         cyc(3, e, (e <= 4) ? 5'b00010 : 5'b00000, 1'b0,
             (e >= 6 && e <= 9) ? 5'b00010 : 5'b00000,
             (e == 6)  ? 5'b00010 : 5'b00000,
             (e == 10) ? 5'b00010 : 5'b00000);
      end
      do_reset(3);

      // Scenario 4: ch2 bounces 1,0,1,0,1 then holds; ch4 toggles every cycle and never settles.
      for (int e = 1; e <= 14; e++) begin
         cyc(4, e, {(e % 2 == 1) ? 1'b1 : 1'b0, 1'b0, (e % 2 == 1 || e > 5) ? 1'b1 : 1'b0, 2'b00},
             1'b0,
             (e >= 10) ? 5'b00100 : 5'b00000,
             (e == 10) ? 5'b00100 : 5'b00000,
             5'b00000);
      end
      do_reset(4);

      // Scenario 5: ch3 rises, then din drops before edge 8 and fall fires at edge 13.
      for (int e = 1; e <= 15; e++) begin
         cyc(5, e, (e <= 7) ? 5'b01000 : 5'b00000, 1'b0,
             (e >= 6 && e <= 12) ? 5'b01000 : 5'b00000,
             (e == 6)  ? 5'b01000 : 5'b00000,
             (e == 13) ? 5'b01000 : 5'b00000);
      end
      do_reset(5);

      // Scenario 6: ch0 step with reset sampled at edge 5; counting restarts, dout at edge 11.
      for (int e = 1; e <= 13; e++) begin
         cyc(6, e, 5'b00001, (e == 5) ? 1'b1 : 1'b0,
             (e >= 11) ? 5'b00001 : 5'b00000,
             (e == 11) ? 5'b00001 : 5'b00000,
             5'b00000);
      end
      do_reset(6);

      // Scenario 7: three channels step together and commit on the same edge.
      for (int e = 1; e <= 8; e++) begin
         cyc(7, e, 5'b10101, 1'b0,
             (e >= 6) ? 5'b10101 : 5'b00000,
             (e == 6) ? 5'b10101 : 5'b00000,
             5'b00000);
      end

      // Drain: the monitor needs one falling edge per queued entry.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain queue left %0d entries expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
